// File: rtl/od_pull_ctrl_if.sv
// Requester-side bundle for od_pull_ctrl: per-requester request, release,
// drive-low and the one-hot grant returned to the requesters.
interface od_pull_ctrl_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0] req_i;
  logic [NREQ-1:0] done_i;
  logic [NREQ-1:0] drv_low_i;
  logic [NREQ-1:0] gnt_o;

  // Requester engines drive requests and sample the grant.
  modport master (output req_i, output done_i, output drv_low_i, input gnt_o);
  // The pad controller consumes requests and returns the grant.
  modport slave  (input req_i, input done_i, input drv_low_i, output gnt_o);
endinterface

// File: rtl/od_pull_ctrl.sv
// Open-drain pad line arbiter/sequencer with an external pull-up.
// Grants the line to one requester at a time, drives the pad low only on the
// owner's request, waits for the pull-up to restore a high level after each
// release and flags a line that stays stuck low (sticky stuck_o).
// Build option: OD_PULL_CTRL_RR_EN selects round-robin arbitration; when it is
// not defined the lowest requesting index wins.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no owner, pad released; arbitrate among pending requests
// S_GRANT   | owner holds the line; pad_oe_o follows owner's drv_low_i
// S_RELEASE | pad released, waiting for filtered line high or stuck timeout
module od_pull_ctrl #(
  parameter int NREQ    = 4,
  parameter int FILT    = 3,
  parameter int RISE_TO = 255
) (
  input  logic           clk,
  input  logic           rstn,
  od_pull_ctrl_if.slave  rq,
  output logic           pad_oe_o,
  input  logic           pad_i,
  output logic           line_o,
  output logic           busy_o,
  output logic           stuck_o,
  input  logic           clr_stuck_i
);

  localparam int FW = $clog2(FILT + 1);
  localparam int CW = $clog2(RISE_TO + 1);
  localparam int OW = $clog2(NREQ);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
  localparam logic [CW-1:0] EXIT_MIN  = CW'(FILT + 2);
  localparam logic [CW-1:0] RISE_LAST = CW'(RISE_TO - 1);
  localparam logic [CW-1:0] RISE_MAX  = CW'(RISE_TO);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_line;
  logic [FW-1:0]   r_filt_cnt;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [OW-1:0]   r_owner;
  logic            r_pad_oe;
  logic [CW-1:0]   r_rcnt;
  logic            r_stuck;

  logic [OW-1:0]   w_win;
  logic            w_any;
  logic            w_release;

`ifdef OD_PULL_CTRL_RR_EN
  logic [OW-1:0]   r_last;
  logic [OW-1:0]   w_idx;
  logic            w_found;

  // Round-robin pick: first requester after the previous owner, wrapping.
  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = OW'((int'(r_last) + k) % NREQ);
      if (!w_found && rq.req_i[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end
`else
  // Fixed priority pick: lowest requesting index wins.
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rq.req_i[k]) w_win = OW'(k);
    end
  end
`endif

  assign w_any     = |rq.req_i;
  assign w_release = rq.done_i[r_owner] || !rq.req_i[r_owner];

  // Pad input: two-flop synchronizer then a FILT-sample agreement filter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_line     <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_sync1 <= pad_i;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_line) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_line     <= r_sync2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  // Ownership sequencer; grant, pad enable, release timer and stuck flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_pad_oe <= 1'b0;
      r_rcnt   <= '0;
      r_stuck  <= 1'b0;
`ifdef OD_PULL_CTRL_RR_EN
      r_last   <= OW'(NREQ - 1);
`endif
    end else begin
      // A stuck event later in this block overrides the clear.
      if (clr_stuck_i) r_stuck <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pad_oe <= 1'b0;
          r_rcnt   <= '0;
          if (w_any) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_owner <= w_win;
`ifdef OD_PULL_CTRL_RR_EN
            r_last  <= w_win;
`endif
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_gnt    <= '0;
            r_pad_oe <= 1'b0;
            r_rcnt   <= '0;
            r_state  <= S_RELEASE;
          end else begin
            r_pad_oe <= rq.drv_low_i[r_owner];
          end
        end
        S_RELEASE: begin
          if ((r_rcnt >= EXIT_MIN) && r_line) begin
            r_state <= S_IDLE;
          end else begin
            if (r_rcnt != RISE_MAX) r_rcnt <= r_rcnt + CW'(1);
            // Counter is about to reach RISE_TO with the line still low.
            if (r_rcnt == RISE_LAST) begin
              r_stuck <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rq.gnt_o = r_gnt;
  assign pad_oe_o = r_pad_oe;
  assign line_o   = r_line;
  assign busy_o   = (r_state != S_IDLE);
  assign stuck_o  = r_stuck;

endmodule
